// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Pipeline hazard control. Tracks a shadow copy of the ID/EX,
//               EX/MEM and MEM/WB control fields and derives the EX operand
//               forwarding selects, the WB->ID register-file bypass selects,
//               load-use / mult-div stalls and branch flushes. Also owns the
//               mult/div busy counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int MDU_LAT = 5            // busy cycles after an MDU start, 1..31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_dst,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       id_mdu_start,
    input  logic       id_uses_mdu,
    input  logic       ex_branch_taken,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB,
    output logic       Gpr_sel_A,
    output logic       Gpr_sel_B,
    output logic       stall,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       mdu_busy
);

    localparam logic [1:0] C_FWD_GPR   = 2'b00;
    localparam logic [1:0] C_FWD_MEMWB = 2'b01;
    localparam logic [1:0] C_FWD_EXMEM = 2'b10;
    localparam logic [4:0] C_MDU_LAT   = 5'(MDU_LAT);

    // The EX stage needs its sources and load flag; later stages only need
    // to know what they will write back.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       reg_write;
    } wb_stage_t;

    ex_stage_t idex_q, idex_d;
    wb_stage_t exmem_q, exmem_d;
    wb_stage_t memwb_q, memwb_d;
    logic [4:0] mdu_cnt_q, mdu_cnt_d;

    logic       w_load_use;
    logic       w_mdu_busy;
    logic       w_stall;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_gpr_a;
    logic       w_gpr_b;

    // Priority select for one EX operand: youngest producer wins. A masked-off
    // source is stored as $0, so the dst != 0 check also blocks it.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input wb_stage_t exm,
                                           input wb_stage_t mwb);
        if (exm.reg_write && (exm.dst != 5'd0) && (exm.dst == src))
            return C_FWD_EXMEM;
        else if (mwb.reg_write && (mwb.dst != 5'd0) && (mwb.dst == src))
            return C_FWD_MEMWB;
        else
            return C_FWD_GPR;
    endfunction

    // Hazard decisions from shadow state and the current ID decode.
    always_comb begin
        w_fwd_a    = fwd_sel(idex_q.rs, exmem_q, memwb_q);
        w_fwd_b    = fwd_sel(idex_q.rt, exmem_q, memwb_q);
        w_gpr_a    = memwb_q.reg_write && (memwb_q.dst != 5'd0) &&
                     (memwb_q.dst == id_rs) && id_use_rs;
        w_gpr_b    = memwb_q.reg_write && (memwb_q.dst != 5'd0) &&
                     (memwb_q.dst == id_rt) && id_use_rt;
        w_load_use = idex_q.mem_read && (idex_q.dst != 5'd0) &&
                     ((id_use_rs && (idex_q.dst == id_rs)) ||
                      (id_use_rt && (idex_q.dst == id_rt)));
        w_mdu_busy = (mdu_cnt_q != 5'd0);
        // A taken branch discards the stalled instruction anyway, so flush wins.
        w_stall    = (w_load_use || (w_mdu_busy && id_uses_mdu)) && !ex_branch_taken;
    end

    // Output drive; everything is held low while reset is asserted.
    always_comb begin
        ForwardA   = 2'b00;
        ForwardB   = 2'b00;
        Gpr_sel_A  = 1'b0;
        Gpr_sel_B  = 1'b0;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        mdu_busy   = 1'b0;
        if (!reset) begin
            ForwardA   = w_fwd_a;
            ForwardB   = w_fwd_b;
            Gpr_sel_A  = w_gpr_a;
            Gpr_sel_B  = w_gpr_b;
            stall      = w_stall;
            flush_ifid = ex_branch_taken;
            flush_idex = ex_branch_taken;
            mdu_busy   = w_mdu_busy;
        end
    end

    // Next shadow-pipeline contents and MDU counter value.
    always_comb begin
        memwb_d   = exmem_q;
        exmem_d   = '{dst: idex_q.dst, reg_write: idex_q.reg_write};
        idex_d    = '0;
        mdu_cnt_d = mdu_cnt_q;
        if (!(w_stall || ex_branch_taken)) begin
            idex_d.rs        = id_use_rs ? id_rs : 5'd0;
            idex_d.rt        = id_use_rt ? id_rt : 5'd0;
            idex_d.dst       = id_dst;
            idex_d.reg_write = id_reg_write;
            idex_d.mem_read  = id_mem_read;
        end
        // Only an MDU op that really enters EX starts the busy window.
        if (id_mdu_start && !w_stall && !ex_branch_taken)
            mdu_cnt_d = C_MDU_LAT;
        else if (mdu_cnt_q != 5'd0)
            mdu_cnt_d = mdu_cnt_q - 5'd1;
    end

    // Shadow pipeline and MDU counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q    <= '0;
            exmem_q   <= '0;
            memwb_q   <= '0;
            mdu_cnt_q <= 5'd0;
        end else begin
            idex_q    <= idex_d;
            exmem_q   <= exmem_d;
            memwb_q   <= memwb_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Scoreboard bench for hazard_forward_unit. Directed pipeline
//               sequences followed by random instruction streams, checked
//               against an instruction-level model of the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    localparam int MDU_LAT = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic       id_use_rs = 0, id_use_rt = 0, id_reg_write = 0, id_mem_read = 0;
    logic       id_mdu_start = 0, id_uses_mdu = 0, ex_branch_taken = 0;
    logic [1:0] ForwardA, ForwardB;
    logic       Gpr_sel_A, Gpr_sel_B, stall, flush_ifid, flush_idex, mdu_busy;

    hazard_forward_unit #(.MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mdu_start(id_mdu_start), .id_uses_mdu(id_uses_mdu),
        .ex_branch_taken(ex_branch_taken),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .Gpr_sel_A(Gpr_sel_A), .Gpr_sel_B(Gpr_sel_B),
        .stall(stall), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ga;
        logic       gb;
        logic       st;
        logic       fi;
        logic       fx;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   running = 0;

    // Instruction-level model: slot 0 = instruction in EX, 1 = MEM, 2 = WB.
    // Sources are -1 when not read; a bubble writes nothing.
    int dst_m[3];
    bit rw_m[3];
    int ex_src_a, ex_src_b;
    bit ex_load;
    int mdu_left;
    bit last_stall;

    function automatic bit writes_reg(int k, int r);
        return rw_m[k] && dst_m[k] != 0 && dst_m[k] == r;
    endfunction

    function automatic logic [1:0] model_fwd(int src);
        if (src < 0)             return 2'b00;
        if (writes_reg(1, src))  return 2'b10;
        if (writes_reg(2, src))  return 2'b01;
        return 2'b00;
    endfunction

    // One clock of stimulus: drive the ID instruction, push the expected
    // outputs for this cycle, then advance the model past the coming edge.
    task automatic cycle(input bit rst, input int rs, input int rt,
                         input bit urs, input bit urt, input int dst,
                         input bit rw, input bit mr, input bit ms,
                         input bit um, input bit br);
        exp_t e;
        bit   hazard;
        @(posedge clk);
        #1;
        reset = rst; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_dst = 5'(dst); id_reg_write = rw; id_mem_read = mr;
        id_mdu_start = ms; id_uses_mdu = um; ex_branch_taken = br;
        e = '0;
        if (!rst) begin
            e.fa   = model_fwd(ex_src_a);
            e.fb   = model_fwd(ex_src_b);
            e.ga   = urs && writes_reg(2, rs);
            e.gb   = urt && writes_reg(2, rt);
            hazard = ex_load && dst_m[0] != 0 &&
                     ((urs && dst_m[0] == rs) || (urt && dst_m[0] == rt));
            e.st   = (hazard || (mdu_left > 0 && um)) && !br;
            e.fi   = br;
            e.fx   = br;
            e.busy = mdu_left > 0;
        end
        exp_q.push_back(e);
        running = 1;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin dst_m[k] = 0; rw_m[k] = 0; end
            ex_src_a = -1; ex_src_b = -1; ex_load = 0; mdu_left = 0;
        end else begin
            dst_m[2] = dst_m[1]; rw_m[2] = rw_m[1];
            dst_m[1] = dst_m[0]; rw_m[1] = rw_m[0];
            if (e.st || br) begin
                dst_m[0] = 0; rw_m[0] = 0; ex_load = 0; ex_src_a = -1; ex_src_b = -1;
            end else begin
                dst_m[0] = dst; rw_m[0] = rw; ex_load = mr;
                ex_src_a = urs ? rs : -1;
                ex_src_b = urt ? rt : -1;
            end
            if (ms && !e.st && !br) mdu_left = MDU_LAT;
            else if (mdu_left > 0)  mdu_left = mdu_left - 1;
        end
        last_stall = e.st && !rst;
    endtask

    // Issue an instruction, re-presenting it while the model says ID is held.
    task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                         input int dst, input bit rw, input bit mr, input bit ms,
                         input bit um, input bit br);
        int n = 0;
        cycle(0, rs, rt, urs, urt, dst, rw, mr, ms, um, br);
        while (last_stall && n < 64) begin
            cycle(0, rs, rt, urs, urt, dst, rw, mr, ms, um, 0);
            n++;
        end
    endtask

    task automatic nop();                       issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input int s, t, d);      issue(s, t, 1, 1, d, 1, 0, 0, 0, 0); endtask
    task automatic lw(input int base, d);       issue(base, 0, 1, 0, d, 1, 1, 0, 0, 0); endtask
    task automatic mult(input int s, t);        issue(s, t, 1, 1, 0, 0, 0, 1, 1, 0); endtask
    task automatic mflo(input int d);           issue(0, 0, 0, 0, d, 1, 0, 0, 1, 0); endtask
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: every cycle the DUT presents a decision, compare it with the
    // oldest expectation in the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ForwardA",   int'(ForwardA),   int'(e.fa));
                chk("ForwardB",   int'(ForwardB),   int'(e.fb));
                chk("Gpr_sel_A",  int'(Gpr_sel_A),  int'(e.ga));
                chk("Gpr_sel_B",  int'(Gpr_sel_B),  int'(e.gb));
                chk("stall",      int'(stall),      int'(e.st));
                chk("flush_ifid", int'(flush_ifid), int'(e.fi));
                chk("flush_idex", int'(flush_idex), int'(e.fx));
                chk("mdu_busy",   int'(mdu_busy),   int'(e.busy));
            end else if (running) begin
                chk("scoreboard_underrun", 0, 1);
            end
        end
    end

    initial begin : stimulus
        int kind, a, b, d;
        for (int k = 0; k < 3; k++) begin dst_m[k] = 0; rw_m[k] = 0; end
        ex_src_a = -1; ex_src_b = -1; ex_load = 0; mdu_left = 0; last_stall = 0;

        do_reset(2);
        // EX/MEM, MEM/WB and WB bypass distances
        alu(1, 2, 3); alu(3, 5, 4); nop(); nop(); nop();
        alu(1, 2, 3); nop(); alu(3, 5, 4); nop(); nop(); nop();
        alu(1, 2, 3); nop(); nop(); alu(3, 5, 4); nop(); nop(); nop();
        // load-use
        lw(1, 4); alu(4, 4, 5); nop(); nop(); nop();
        // writes to $0 are never forwarded
        alu(1, 2, 0); lw(1, 0); alu(0, 0, 7); alu(0, 0, 8); nop(); nop(); nop();
        // mult/div busy window
        mult(1, 2); mflo(3); nop(); nop(); nop();
        // reset mid-count
        mult(1, 2); nop(); nop(); do_reset(1); mflo(3); nop();
        // branch in the same cycle as a load-use hazard
        lw(1, 4); issue(4, 4, 1, 1, 5, 1, 0, 0, 0, 1); alu(4, 4, 6); nop(); nop(); nop();
        // both EX/MEM and MEM/WB write $6
        alu(1, 2, 6); alu(2, 3, 6); alu(6, 6, 7); nop(); nop(); nop();

        // randomized instruction stream over a small register set
        for (int i = 0; i < 1500; i++) begin
            kind = $urandom_range(0, 99);
            a = $urandom_range(0, 3); b = $urandom_range(0, 3); d = $urandom_range(0, 3);
            if (kind < 2)       do_reset(1);
            else if (kind < 12) issue(a, b, $urandom_range(0, 1), $urandom_range(0, 1),
                                      d, 1, 0, 0, 0, 1);
            else if (kind < 45) issue(a, b, $urandom_range(0, 1), $urandom_range(0, 1),
                                      d, $urandom_range(0, 1), 0, 0, 0, 0);
            else if (kind < 65) lw(a, d);
            else if (kind < 72) mult(a, b);
            else if (kind < 80) mflo(d);
            else                nop();
        end

        @(negedge clk);
        #1;
        running = 0;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Pipeline control block that produces the select lines the datapath forwarding and bypass muxes consume.
- Outputs: ForwardA/ForwardB for the EX operand muxes, Gpr_sel_A/Gpr_sel_B for the WB->ID register-file bypass, and stall/flush controls for the PC, IF/ID and ID/EX registers.
- Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB control fields (dst, RegWrite, MemRead, sources), so the datapath only presents ID-stage decode information.
- Also owns the multi-cycle mult/div busy counter.

Parameters:
- MDU_LAT, 5, cycles the mult/div unit stays busy after an MDU start op enters EX; legal range 1..31.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- id_rs  input  5  rs field [25:21] of the instruction in ID
- id_rt  input  5  rt field [20:16] of the instruction in ID
- id_use_rs  input  1  ID instruction reads rs
- id_use_rt  input  1  ID instruction reads rt
- id_dst  input  5  destination register after the RegDst selection (rt, rd or 31)
- id_reg_write  input  1  ID instruction writes the GPR file
- id_mem_read  input  1  ID instruction is a load
- id_mdu_start  input  1  ID instruction is mult/multu/div/divu
- id_uses_mdu  input  1  ID instruction is an MDU op or mfhi/mflo/mthi/mtlo
- ex_branch_taken  input  1  branch/jump resolved taken in EX
- ForwardA  output  2  EX operand A select: 00 GPR, 01 MEM/WB data, 10 EX/MEM ALU result
- ForwardB  output  2  same encoding, operand B
- Gpr_sel_A  output  1  1 = ID rs read takes WB write data
- Gpr_sel_B  output  1  1 = ID rt read takes WB write data
- stall  output  1  hold PC and IF/ID; bubble into ID/EX
- flush_ifid  output  1  clear IF/ID
- flush_idex  output  1  clear ID/EX
- mdu_busy  output  1  mult/div unit in progress

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset:
  - All shadow stages become bubbles (reg_write=0, mem_read=0, dst=0, rs=rt=0).
  - MDU counter is cleared to 0.
  - While reset is high, every output is forced to 0.
  - Reset asserted mid-MDU clears mdu_busy on the next edge.
- Shadow pipeline, updated every edge:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= the ID fields (rs masked by use_rs, rt masked by use_rt), or a bubble when stall=1 or flush_idex=1.
- Forwarding (combinational from the shadow state; a match requires reg_write=1, dst!=0 and dst==source):
  - EX/MEM match -> 10.
  - Else MEM/WB match -> 01.
  - Else 00.
  - When both stages match, EX/MEM has priority.
  - A source gated off by use_rs/use_rt never forwards.
- WB bypass:
  - Gpr_sel_A = MEM/WB.reg_write & MEM/WB.dst!=0 & MEM/WB.dst==id_rs & id_use_rs.
  - Gpr_sel_B is the same, using id_rt and id_use_rt.
- Load-use hazard:
  - Condition: ID/EX.mem_read & ID/EX.dst!=0 & (use_rs & dst==id_rs | use_rt & dst==id_rt).
  - Asserts stall for exactly one cycle.
  - The next cycle the load is in EX/MEM and the consumer re-evaluates with no hazard.
- MDU:
  - When an ID instruction with id_mdu_start advances into ID/EX (no stall, no flush), the counter loads MDU_LAT.
  - Otherwise the counter decrements while nonzero.
  - mdu_busy = (counter != 0).
  - stall is also asserted while mdu_busy & id_uses_mdu.
  - A flushed or stalled MDU start does not load the counter.
- Flush:
  - ex_branch_taken=1 -> flush_ifid=1 and flush_idex=1 in the same cycle, combinationally.
  - Flush overrides stall: stall is forced to 0 and the ID/EX shadow takes a bubble.
- Latency: all outputs are combinational from current inputs and registered state; zero-cycle decision.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 -> sub in EX: ForwardA=10. With one nop between them -> ForwardA=01. With two nops -> Gpr_sel_A=1 in sub's ID cycle and ForwardA=00.
- lw $4,0($1) then add $5,$4,$4 -> stall=1 for exactly one cycle, then ForwardA=ForwardB=01 in add's EX cycle; no second stall.
- Writes to $0 by add or lw followed by a reader of $0 -> ForwardA/B=00, stall=0, Gpr_sel=0.
- MDU_LAT=5: mult $1,$2 then mflo $3 -> mdu_busy high 5 cycles, stall high while mflo waits, mflo proceeds the cycle after mdu_busy falls. Repeat with reset pulsed mid-count -> busy=0 next cycle.
- ex_branch_taken=1 in the same cycle as a load-use hazard -> flush_ifid=1, flush_idex=1, stall=0. The next cycle ID/EX holds a bubble (no forwarding from it).
- EX/MEM and MEM/WB both write $6, then EX reads $6 on both operands -> ForwardA=ForwardB=10.
